ro_puf_sequencer: RTL
=====================

// Module: ro_puf_sequencer
// PURPOSE
// - Sequences an N-bit ring-oscillator PUF array. Latches a challenge, clears the array,
//   runs one evaluation, waits for every bit's finish flag or a timeout, then presents the
//   response over a valid/ready handshake.
// - Sits between the top-level I/O wrapper and the replicated puf_bit instances.
//   Replaces direct wiring of ui_in, rst and ena into the array.
// PARAMETERS
// - N_BITS      8     number of PUF bits (array width, response width)
// - CW          8     challenge width driven to every bit
// - CLR_CYCLES  4     cycles the array is held in reset before each evaluation (>=1)
// - TIMEOUT     4096  max RUN cycles before aborting an evaluation (>=2)
// - VOTES       5     evaluations per response when PUF_VOTE_EN is defined (odd, >=1)
// PORTS
// - clk          in   1       system clock, all logic rising-edge
// - rst_n        in   1       asynchronous, active-low reset
// - start        in   1       request evaluation; sampled only in IDLE
// - challenge    in   CW      challenge; captured on accepted start
// - busy         out  1       high in every state except IDLE
// - puf_challenge out CW      registered challenge to the array, stable CLEAR..CAPTURE
// - puf_rst      out  1       active-high reset to the array
// - puf_en       out  1       enable to the array
// - puf_out      in   N_BITS  raw bit values from the array
// - puf_finish   in   N_BITS  per-bit finish flags from the array
// - resp         out  N_BITS  response, valid while resp_valid=1
// - resp_valid   out  1       response available
// - resp_ready   in   1       consumer accepts response
// - timeout_err  out  1       the response includes at least one timed-out evaluation
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; busy=0, puf_rst=1, puf_en=0, puf_challenge=0,
//   resp=0, resp_valid=0, timeout_err=0, all counters=0. Reset mid-operation aborts
//   immediately with no partial response.
// - FSM: IDLE -> CLEAR -> RUN -> CAPTURE -> (CLEAR | DONE) -> IDLE.
// - IDLE: puf_rst=1, puf_en=0. If start=1 at an edge, capture challenge into
//   puf_challenge, clear timeout_err, go to CLEAR. A start outside IDLE is ignored.
// - CLEAR: puf_rst=1, puf_en=0 for exactly CLR_CYCLES cycles, then RUN.
// - RUN: puf_rst=0, puf_en=1. run_cnt counts from 0 each cycle.
//   - &puf_finish=1: go to CAPTURE.
//   - Otherwise, when run_cnt==TIMEOUT-1: set timeout_err sticky and go to CAPTURE.
//   - If finish completes on the timeout cycle, finish wins and no error is flagged.
// - CAPTURE (1 cycle): puf_en=0. sample = puf_out & puf_finish, so bits that never
//   finished read 0. Fold sample into the result, then go to DONE
//   (or back to CLEAR, see CONFIGURATION).
// - DONE: resp_valid=1 and resp held stable. Leave for IDLE on the edge where
//   resp_valid & resp_ready. resp keeps its value until the next CAPTURE.
// - Latency from start edge to resp_valid (single evaluation, finish after F RUN cycles):
//   CLR_CYCLES + F + 2 cycles. The worst case uses TIMEOUT in place of F.
// - run_cnt width is $clog2(TIMEOUT). Counters saturate, never wrap.
// - puf_finish is assumed synchronous to clk.
// CONFIGURATION
// - PUF_VOTE_EN defined:
//   - Each request runs VOTES evaluations (CAPTURE -> CLEAR until eval_cnt==VOTES-1).
//   - Per-bit ones-counters of width $clog2(VOTES+1) accumulate samples.
//   - resp[i] = ones[i] > VOTES/2.
//   - timeout_err is set if any evaluation timed out. Counters are cleared on start accept.
// - PUF_VOTE_EN undefined: one evaluation, resp = sample. VOTES is ignored and no vote
//   counters are synthesized.
// TESTING
// - Finish after 10 RUN cycles, puf_out=8'hA5, challenge=8'h3C:
//   puf_challenge=8'h3C, resp=8'hA5, resp_valid at start+16, timeout_err=0.
// - puf_finish=8'h7F held forever, puf_out=8'hFF:
//   after TIMEOUT RUN cycles, resp=8'h7F and timeout_err=1.
// - resp_ready=0 for 20 cycles in DONE, with start pulses: resp stays stable, starts are
//   ignored; resp_ready=1 -> IDLE the next cycle.
// - rst_n=0 mid-RUN: outputs return to reset values immediately; the next start runs
//   a clean evaluation.
// - PUF_VOTE_EN with VOTES=5, bit0 samples 1,0,1,1,0 and all others 0:
//   resp=8'h01 after 5 evaluations.
// - Finish and timeout on the same cycle: timeout_err=0 and resp = the sampled bits.

Source files
------------

// File: rtl/ro_puf_sequencer.sv
// ---------------------------------------------------------------------------
// ro_puf_sequencer
//
// Purpose:
//   Drives an N_BITS-wide ring-oscillator PUF array through one request:
//   latch a challenge, hold the array in reset, run an evaluation until
//   every bit reports finish (or a timeout expires), sample the masked raw
//   bits, then offer the response over a valid/ready handshake.
//
// Optional feature (macro PUF_VOTE_EN):
//   When defined, each request runs VOTES evaluations and every response
//   bit is a majority vote over the per-evaluation samples. When undefined,
//   a single evaluation is run, its sample is the response, and no vote
//   counters exist.
//
// Ports:
//   clk            in   1       system clock, rising edge
//   rst_n          in   1       asynchronous active-low reset
//   start          in   1       evaluation request, sampled only in IDLE
//   challenge      in   CW      challenge, captured when start is accepted
//   busy           out  1       high whenever the sequencer is not IDLE
//   puf_challenge  out  CW      registered challenge driven to the array
//   puf_rst        out  1       active-high reset to the array
//   puf_en         out  1       enable to the array
//   puf_out        in   N_BITS  raw bit values from the array
//   puf_finish     in   N_BITS  per-bit finish flags (synchronous to clk)
//   resp           out  N_BITS  response, valid while resp_valid is high
//   resp_valid     out  1       response available
//   resp_ready     in   1       consumer accepts the response
//   timeout_err    out  1       at least one evaluation of this response timed out
// ---------------------------------------------------------------------------
module ro_puf_sequencer #(
  parameter int N_BITS     = 8,
  parameter int CW         = 8,
  parameter int CLR_CYCLES = 4,
  parameter int TIMEOUT    = 4096,
  parameter int VOTES      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CW-1:0]     challenge,
  output logic              busy,
  output logic [CW-1:0]     puf_challenge,
  output logic              puf_rst,
  output logic              puf_en,
  input  logic [N_BITS-1:0] puf_out,
  input  logic [N_BITS-1:0] puf_finish,
  output logic [N_BITS-1:0] resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  // A one-cycle clear still needs a 1-bit counter.
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int RUN_W = $clog2(TIMEOUT);

  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

  state_t              state_q;
  logic                busy_q;
  logic                puf_rst_q;
  logic                puf_en_q;
  logic [CW-1:0]       puf_challenge_q;
  logic [N_BITS-1:0]   resp_q;
  logic                resp_valid_q;
  logic                timeout_err_q;
  logic [CLR_W-1:0]    clr_cnt_q;
  logic [RUN_W-1:0]    run_cnt_q;

  // Bits that never finished read as 0.
  logic [N_BITS-1:0]   sample_d;
  logic                all_done_d;

  assign sample_d   = puf_out & puf_finish;
  assign all_done_d = &puf_finish;

  // Elaboration-time sanity hook: an even VOTES would allow ties.
  if ((VOTES % 2) == 0) begin : g_votes_must_be_odd
  end

`ifdef PUF_VOTE_EN
  localparam int VOTE_W = $clog2(VOTES + 1);
  localparam int EVAL_W = (VOTES > 1) ? $clog2(VOTES) : 1;

  localparam logic [EVAL_W-1:0] EVAL_LAST = EVAL_W'(VOTES - 1);
  localparam logic [VOTE_W-1:0] VOTE_HALF = VOTE_W'(VOTES / 2);
  localparam logic [VOTE_W-1:0] VOTE_MAX  = VOTE_W'(VOTES);

  logic [N_BITS-1:0][VOTE_W-1:0] ones_q;
  logic [N_BITS-1:0][VOTE_W-1:0] ones_d;
  logic [N_BITS-1:0]             majority_d;
  logic [EVAL_W-1:0]             eval_cnt_q;
  logic                          vote_clear;
  logic                          vote_accum;

  assign vote_clear = (state_q == S_IDLE) && start;
  assign vote_accum = (state_q == S_CAPTURE);

  // Per-bit ones counters; the majority uses the count including the
  // current sample so the last CAPTURE can publish the result directly.
  for (genvar gi = 0; gi < N_BITS; gi++) begin : g_vote
    assign ones_d[gi] = (ones_q[gi] == VOTE_MAX) ? ones_q[gi]
                      : ones_q[gi] + VOTE_W'(sample_d[gi]);
    assign majority_d[gi] = (ones_d[gi] > VOTE_HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else if (vote_clear) begin
      ones_q <= '0;
    end else if (vote_accum) begin
      ones_q <= ones_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      puf_rst_q       <= 1'b1;
      puf_en_q        <= 1'b0;
      puf_challenge_q <= '0;
      resp_q          <= '0;
      resp_valid_q    <= 1'b0;
      timeout_err_q   <= 1'b0;
      clr_cnt_q       <= '0;
      run_cnt_q       <= '0;
`ifdef PUF_VOTE_EN
      eval_cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          puf_rst_q <= 1'b1;
          puf_en_q  <= 1'b0;
          if (start) begin
            puf_challenge_q <= challenge;
            timeout_err_q   <= 1'b0;
            clr_cnt_q       <= '0;
            run_cnt_q       <= '0;
            busy_q          <= 1'b1;
`ifdef PUF_VOTE_EN
            eval_cnt_q      <= '0;
`endif
            state_q         <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            puf_rst_q <= 1'b0;
            puf_en_q  <= 1'b1;
            run_cnt_q <= '0;
            state_q   <= S_RUN;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end

        S_RUN: begin
          // Finish takes priority, so a finish landing on the last
          // allowed cycle is not reported as a timeout.
          if (all_done_d) begin
            puf_en_q <= 1'b0;
            state_q  <= S_CAPTURE;
          end else if (run_cnt_q == RUN_LAST) begin
            puf_en_q      <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= S_CAPTURE;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end

        S_CAPTURE: begin
          // puf_rst stays low this cycle so the array holds its values.
`ifdef PUF_VOTE_EN
          if (eval_cnt_q == EVAL_LAST) begin
            resp_q       <= majority_d;
            resp_valid_q <= 1'b1;
            puf_rst_q    <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            eval_cnt_q <= eval_cnt_q + 1'b1;
            clr_cnt_q  <= '0;
            puf_rst_q  <= 1'b1;
            state_q    <= S_CLEAR;
          end
`else
          resp_q       <= sample_d;
          resp_valid_q <= 1'b1;
          puf_rst_q    <= 1'b1;
          state_q      <= S_DONE;
`endif
        end

        S_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          puf_rst_q    <= 1'b1;
          puf_en_q     <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign puf_challenge = puf_challenge_q;
  assign puf_rst       = puf_rst_q;
  assign puf_en        = puf_en_q;
  assign resp          = resp_q;
  assign resp_valid    = resp_valid_q;
  assign timeout_err   = timeout_err_q;

endmodule
